// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] CHK_INIT = 8'h00;
    localparam int         WORD_W   = 16;
    localparam int         BYTE_W   = 8;

endpackage

// File: rtl/loader_xsum.sv
// XOR accumulator for the payload checksum of an instruction load.
// Clear has priority over enable so a restart always begins from CHK_INIT.
module loader_xsum
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] sum
);

    logic [BYTE_W-1:0] sum_q;
    logic [BYTE_W-1:0] sum_d;

    // Next accumulator value: clear, fold in a byte, or hold.
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = CHK_INIT;
        end else if (en) begin
            sum_d = sum_q ^ din;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= CHK_INIT;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: frames a byte stream as a 16-bit word count,
// big-endian 16-bit instructions and (optionally) an XOR checksum, writes
// each word to the instruction RAM and releases the CPU reset on success.
// Build option: define LOADER_CHECKSUM_EN to add the trailing checksum byte
// and its compare; without it a load completes after the last word.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [15:0]       words_loaded,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    // Word count is 16 bits wide, so compare against DEPTH with one extra
    // bit to cover a full 2**16-word memory.
    localparam int               DEPTH   = 1 << ADDR_W;
    localparam logic [WORD_W:0]  DEPTH_W = 17'(DEPTH);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   count_q, count_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [WORD_W-1:0]   words_q, words_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic [WORD_W-1:0]   hdr_count;
    logic                oversize;
    logic                last_word;

    assign s_ready   = !reload && (state_q inside {HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK});
    assign accept    = s_valid && s_ready;
    assign hdr_count = {count_q[15:8], s_data};
    assign oversize  = {1'b0, hdr_count} > DEPTH_W;
    assign last_word = (words_q + 16'd1) == count_q;

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xsum;
    logic              xsum_en;

    assign xsum_en = accept && ((state_q == DATA_HI) || (state_q == DATA_LO));

    loader_xsum u_xsum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (reload),
        .en    (xsum_en),
        .din   (s_data),
        .sum   (xsum)
    );
`endif

    // Framing state machine and write-port/status next values.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hi_d        = hi_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;
        done_d      = done_q;
        err_d       = err_q;

        if (reload) begin
            state_d = HDR_HI;
            count_d = '0;
            words_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                HDR_HI: begin
                    if (accept) begin
                        count_d = {s_data, 8'h00};
                        state_d = HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        count_d = hdr_count;
                        if (oversize) begin
                            err_d   = 1'b1;
                            state_d = ERR;
                        end else if (hdr_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end else begin
                            state_d = DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (accept) begin
                        hi_d    = s_data;
                        state_d = DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (accept) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = words_q[ADDR_W-1:0];
                        mem_wdata_d = {hi_q, s_data};
                        words_d     = words_q + 16'd1;
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end else begin
                            state_d = DATA_HI;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        if (s_data == xsum) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ERR;
                        end
                    end
                end
`endif
                DONE: begin
`ifndef LOADER_CHECKSUM_EN
                    done_d = 1'b1;
`endif
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = HDR_HI;
                end
            endcase
        end
    end

    // State, framing and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HDR_HI;
            count_q     <= '0;
            hi_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            words_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = words_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cpu_rst_n    = done_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write side of the instruction memory that the fetch stage reads.
- Accepts a byte stream over a valid/ready handshake, frames it as a word count plus big-endian 16-bit instructions plus an XOR checksum, and writes each word to the instruction memory write port.
- Holds the CPU in reset (cpu_rst_n low) until a load completes cleanly. Sits beside the cpu top, between the host/debug link and the instruction RAM.

Parameters:
- ADDR_W, 8, instruction memory address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous assert, active-low (fixed)
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_ready  out  1  loader accepts byte; transfer when s_valid && s_ready
- reload  in  1  synchronous restart pulse
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  16  write data {hi,lo}
- words_loaded  out  16  count of words written this load
- done  out  1  load complete, checksum good
- err  out  1  load failed (oversize or checksum)
- cpu_rst_n  out  1  active-low reset to cpu; high only while done

Behaviour:
- Reset (rst_n low, async):
  - state=HDR_HI
  - mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0
  - done=0, err=0, cpu_rst_n=0
  - count and checksum registers cleared
- s_ready is combinational: 1 in HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK, and reload=0; 0 otherwise.
- States and transitions (all on an accepted byte unless noted):
  - HDR_HI: latch count[15:8] -> HDR_LO.
  - HDR_LO: latch count[7:0].
    - count > DEPTH -> ERR.
    - count == 0 -> CHK.
    - else -> DATA_HI.
  - DATA_HI: latch hi byte, xor into checksum -> DATA_LO.
  - DATA_LO: xor lo byte into checksum. Next edge: mem_we=1, mem_addr=word index, mem_wdata={hi,lo}, word index++, words_loaded++.
    - Last word -> CHK.
    - Else -> DATA_HI.
  - CHK: byte == checksum -> DONE (done=1, cpu_rst_n=1 on the same edge); else -> ERR (err=1).
  - DONE / ERR: s_ready=0; hold until reload or rst_n.
- Latency:
  - Memory write is registered, one cycle after the DATA_LO byte is accepted.
  - The last write always precedes done by ≥1 cycle.
- Checksum:
  - 8-bit XOR of payload bytes only; header bytes are excluded.
  - Initial value 0x00, so N=0 expects 0x00.
- mem_we deasserts the cycle after each pulse. mem_addr and mem_wdata hold their last values.
- Word index wraps never: count ≤ DEPTH is guaranteed by the HDR_LO check. count == DEPTH is legal, and the last address is DEPTH-1.
- reload:
  - In any state, on the next edge: state=HDR_HI, done=0, err=0, cpu_rst_n=0, words_loaded=0, count, index and checksum cleared.
  - reload forces s_ready=0, so a coincident byte is not accepted.
  - Memory contents are not cleared.
- s_valid gaps are tolerated in every state; the state machine only advances on accepted bytes.
- rst_n mid-load: async return to reset values. A partially written memory is acceptable.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: CHK state and checksum compare as above.
- Undefined:
  - No CHK state. Last DATA_LO (or HDR_LO with count=0) -> DONE, with done and cpu_rst_n rising on the edge after the final write.
  - err is raised only on oversize.
  - The checksum register is removed.

Decomposition:
- Package imem_loader_pkg:
  - state enum (HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK, DONE, ERR)
  - CHK_INIT=8'h00
  - WORD_W=16, BYTE_W=8
- One natural sub-module, loader_xsum: XOR accumulator with clear/enable, async rst_n. It is instantiated only under LOADER_CHECKSUM_EN.

Test Plan:
- Good load, ADDR_W=8, bytes 00 02 A1 23 4B 56 9F -> mem_we pulses at addr 0 data A123, then addr 1 data 4B56; done=1, cpu_rst_n=1, err=0, words_loaded=2, s_ready=0.
- Bad checksum, same stream ending 9E -> two writes occur; err=1, done=0, cpu_rst_n=0.
- Oversize header 01 01 (257 > 256) -> err=1 after the second byte; no mem_we; s_ready=0.
- Empty load 00 00 00 -> done=1, words_loaded=0, zero mem_we pulses. With the macro undefined, bytes 00 00 -> done=1.
- reload after 3 accepted bytes, asserted coincident with a valid byte -> byte not accepted, state=HDR_HI, words_loaded=0. A following good stream 00 01 12 34 26 -> write addr 0 data 1234, done=1.
- Random s_valid gaps plus rst_n pulse mid-DATA_LO -> all outputs go to reset values asynchronously. A subsequent good load completes correctly.
